// File: rtl/control_unit.sv
// Hardwired control unit: a Moore FSM that sequences fetch, decode and the
// per-class execute steps (ALU, addi, mul, ld, st, halt) and decodes the
// datapath strobes from the current state and the IR.
module control_unit #(
  parameter bit RESET_RUN = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run_req,
  input  logic        mem_done,
  input  logic [31:0] ir,
  output logic [15:0] ctl,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic [4:0]  alu_op,
  output logic [31:0] c_sext,
  output logic        run,
  output logic        illegal
);

  // Strobe bit positions within ctl.
  localparam int unsigned PcOut    = 0;
  localparam int unsigned PcIn     = 1;
  localparam int unsigned IrIn     = 2;
  localparam int unsigned MarIn    = 3;
  localparam int unsigned MdrIn    = 4;
  localparam int unsigned MdrOut   = 5;
  localparam int unsigned Read     = 6;
  localparam int unsigned Write    = 7;
  localparam int unsigned YIn      = 8;
  localparam int unsigned ZIn      = 9;
  localparam int unsigned ZlowOut  = 10;
  localparam int unsigned ZhighOut = 11;
  localparam int unsigned HiIn     = 12;
  localparam int unsigned LoIn     = 13;
  localparam int unsigned COut     = 14;
  localparam int unsigned IncPc    = 15;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpHalt = 5'b11011;

  // StBoot is the post-reset holding state used when RESET_RUN is set;
  // StFetch1W is the FETCH1 wait phase, where PCin must no longer fire.
  typedef enum logic [3:0] {
    StHalt, StBoot, StFetch0, StFetch1, StFetch1W, StFetch2, StDecode,
    StT3, StT4, StT5, StT6, StT7
  } state_e;

  state_e state_q, state_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_addi, is_mul, is_ld, is_st, is_halt, is_mem, legal;

  assign opcode  = ir[31:27];
  assign ra      = ir[26:23];
  assign rb      = ir[22:19];
  assign rc      = ir[18:15];
  assign is_alu  = (opcode == OpAdd) || (opcode == OpSub) || (opcode == OpAnd) ||
                   (opcode == OpOr);
  assign is_addi = (opcode == OpAddi);
  assign is_mul  = (opcode == OpMul);
  assign is_ld   = (opcode == OpLd);
  assign is_st   = (opcode == OpSt);
  assign is_halt = (opcode == OpHalt);
  assign is_mem  = is_ld || is_st;
  assign legal   = is_alu || is_addi || is_mul || is_mem || is_halt;

  // State register, asynchronously forced to the reset state by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      if (RESET_RUN) state_q <= StBoot;
      else           state_q <= StHalt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_done only matters in the three wait states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalt:    if (run_req) state_d = StFetch0;
      StBoot:    state_d = StFetch0;
      StFetch0:  state_d = StFetch1;
      StFetch1: begin
        if (mem_done) state_d = StFetch2;
        else          state_d = StFetch1W;
      end
      StFetch1W: if (mem_done) state_d = StFetch2;
      StFetch2:  state_d = StDecode;
      StDecode: begin
        if (is_halt)     state_d = StHalt;
        else if (!legal) state_d = StFetch0;
        else             state_d = StT3;
      end
      StT3:      state_d = StT4;
      StT4:      state_d = StT5;
      StT5: begin
        if (is_mul || is_mem) state_d = StT6;
        else                  state_d = StFetch0;
      end
      StT6: begin
        if (is_mul)        state_d = StFetch0;
        else if (is_st)    state_d = StT7;
        else if (mem_done) state_d = StT7;
      end
      StT7:      if (is_ld || mem_done) state_d = StFetch0;
      default:   state_d = StHalt;
    endcase
  end

  // Moore output decode; everything is forced low while clr is asserted.
  always_comb begin
    ctl     = '0;
    reg_in  = '0;
    reg_out = '0;
    alu_op  = '0;
    illegal = 1'b0;
    run     = (state_q != StHalt);
    c_sext  = {{13{ir[18]}}, ir[18:0]};
    unique case (state_q)
      StFetch0: begin
        ctl[PcOut] = 1'b1;
        ctl[MarIn] = 1'b1;
        ctl[IncPc] = 1'b1;
        ctl[ZIn]   = 1'b1;
      end
      StFetch1: begin
        ctl[ZlowOut] = 1'b1;
        ctl[PcIn]    = 1'b1;
        ctl[Read]    = 1'b1;
        ctl[MdrIn]   = 1'b1;
      end
      StFetch1W: begin
        ctl[Read]  = 1'b1;
        ctl[MdrIn] = 1'b1;
      end
      StFetch2: begin
        ctl[MdrOut] = 1'b1;
        ctl[IrIn]   = 1'b1;
      end
      StDecode: illegal = !legal;
      StT3: begin
        if (is_mul) reg_out[ra] = 1'b1;
        else        reg_out[rb] = 1'b1;
        ctl[YIn] = 1'b1;
      end
      StT4: begin
        ctl[ZIn] = 1'b1;
        if (is_alu) begin
          reg_out[rc] = 1'b1;
          alu_op      = opcode;
        end else if (is_mul) begin
          reg_out[rb] = 1'b1;
          alu_op      = OpMul;
        end else begin
          ctl[COut] = 1'b1;
          alu_op    = OpAdd;
        end
      end
      StT5: begin
        ctl[ZlowOut] = 1'b1;
        if (is_mul)      ctl[LoIn]   = 1'b1;
        else if (is_mem) ctl[MarIn]  = 1'b1;
        else             reg_in[ra]  = 1'b1;
      end
      StT6: begin
        if (is_mul) begin
          ctl[ZhighOut] = 1'b1;
          ctl[HiIn]     = 1'b1;
        end else if (is_ld) begin
          ctl[Read]  = 1'b1;
          ctl[MdrIn] = 1'b1;
        end else begin
          reg_out[ra] = 1'b1;
          ctl[MdrIn]  = 1'b1;
        end
      end
      StT7: begin
        if (is_ld) begin
          ctl[MdrOut] = 1'b1;
          reg_in[ra]  = 1'b1;
        end else begin
          ctl[Write] = 1'b1;
        end
      end
      default: ;
    endcase
    if (!clr) begin
      ctl     = '0;
      reg_in  = '0;
      reg_out = '0;
      alu_op  = '0;
      illegal = 1'b0;
      run     = 1'b0;
      c_sext  = '0;
    end
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_RUN, default 0; 1 = leave reset directly into FETCH0, 0 = leave reset into HALT.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-low.
REQ-004 run_req  in  1  start request, sampled in HALT only.
REQ-005 mem_done  in  1  memory handshake completion, sampled in FETCH1, LD_T6, ST_T7.
REQ-006 ir  in  32  IR contents from datapath; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15], C ir[18:0].
REQ-007 ctl  out  16  datapath strobes; bit map: 0 PCout, 1 PCin, 2 IRin, 3 MARin, 4 MDRin, 5 MDRout, 6 Read, 7 Write, 8 Yin, 9 Zin, 10 Zlowout, 11 Zhighout, 12 HIin, 13 LOin, 14 Cout, 15 IncPC.
REQ-008 reg_in  out  16  one-hot general-register load enables (R0in..R15in).
REQ-009 reg_out  out  16  one-hot general-register bus drives (R0out..R15out).
REQ-010 alu_op  out  5  ALU OpCode; 00000 when no ALU cycle.
REQ-011 c_sext  out  32  ir[18:0] sign-extended from bit 18; valid whenever ctl[14] is set.
REQ-012 run  out  1  high in every state except HALT.
REQ-013 illegal  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-014 Moore FSM: ctl, reg_in, reg_out, alu_op, run are decoded from current state and ir only; mem_done affects transitions, never outputs.
REQ-015 At most one bit of reg_out plus at most one of ctl{PCout,MDRout,Zlowout,Zhighout,Cout} set per cycle (single bus driver).
REQ-016 Opcodes: 00000 ld, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 01100 addi, 01111 mul, 11011 halt; all others undefined.
REQ-017 FETCH0: PCout, MARin, IncPC, Zin -> FETCH1.
REQ-018 FETCH1: Zlowout, PCin (first cycle only), Read, MDRin; held with Read, MDRin while mem_done=0; -> FETCH2 in the cycle mem_done=1.
REQ-019 FETCH2: MDRout, IRin -> DECODE (T3 of decoded class, one cycle later, ir now valid).
REQ-020 add/sub/and/or: T3 reg_out[Rb], Yin; T4 reg_out[Rc], alu_op=opcode, Zin; T5 Zlowout, reg_in[Ra] -> FETCH0.
REQ-021 addi: T3 reg_out[Rb], Yin; T4 Cout, alu_op=00011, Zin; T5 Zlowout, reg_in[Ra] -> FETCH0.
REQ-022 mul: T3 reg_out[Ra], Yin; T4 reg_out[Rb], alu_op=01111, Zin; T5 Zlowout, LOin; T6 Zhighout, HIin -> FETCH0.
REQ-023 ld/st address: T3 reg_out[Rb], Yin; T4 Cout, alu_op=00011, Zin; T5 Zlowout, MARin.
REQ-024 ld: T6 Read, MDRin, held until mem_done=1; T7 MDRout, reg_in[Ra] -> FETCH0.
REQ-025 st: T6 reg_out[Ra], MDRin (Read=0); T7 Write, held until mem_done=1 -> FETCH0.
REQ-026 halt: DECODE -> HALT; HALT drives all outputs 0; run_req=1 sampled -> FETCH0.
REQ-027 Undefined opcode: DECODE asserts illegal one cycle, no strobes, -> FETCH0 (treated as nop).
REQ-028 mem_done asserted outside a wait state is ignored; no timeout on waits.
REQ-029 Cycle counts with mem_done tied 1: ALU/addi 7, mul 8, ld/st 9 cycles FETCH0-to-FETCH0 (includes DECODE).

Reset
REQ-030 clr=0 forces state HALT (RESET_RUN=0) or FETCH0-pending (RESET_RUN=1) immediately, independent of clk.
REQ-031 During reset all outputs 0, including mid-wait (Read/Write drop asynchronously).
REQ-032 With RESET_RUN=1, first rising edge after clr deasserts enters FETCH0.

Verification
REQ-033 Reset, run_req=1 one cycle, mem_done=1, ir=0x19A20000 (add R3,R4,R4) -> FETCH0 ctl=0x8209, T4 alu_op=00011, T5 reg_in=0x0008, ctl=0x0400.
REQ-034 ld R1,0x10(R2), mem_done held 0 for 3 cycles in T6 -> Read+MDRin held 3+1 cycles, T7 reg_in=0x0002, ctl=0x0020.
REQ-035 mul R5,R6 -> T5 ctl=0x2400, T6 ctl=0x1800, T4 alu_op=01111; C=0x7FFFF with addi -> c_sext=0xFFFFFFFF.
REQ-036 ir opcode 10101 -> illegal high exactly one cycle, then FETCH0, no reg_in bit set.
REQ-037 clr pulsed low during st T7 wait -> Write drops same cycle, run=0, state HALT; halt opcode -> run=0 until run_req.
